// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared encodings for the fetch redirect controller: next-PC source selects,
// FSM states and the default drain length.
package fetch_redirect_ctrl_pkg;

  // Next-PC source select driven to the PC register block.
  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JAL  = 2'b10;
  localparam logic [1:0] PCSRC_JALR = 2'b11;

  localparam int unsigned FLUSH_CYCLES_DEFAULT = 2;

  // Drain window is at most 7 cycles.
  localparam int unsigned DrainCntW = 3;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stall_watchdog.sv
// Stall watchdog: counts consecutive hold cycles (capped at 16 bits) and raises
// a sticky timeout flag once the run reaches STALL_TIMEOUT. Only rst clears it.
module fetch_stall_watchdog #(
  parameter int unsigned STALL_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic hold_i,
  output logic timeout_o
);

  localparam logic [16:0] Limit = 17'(STALL_TIMEOUT);

  logic [15:0] cnt_q, cnt_d;
  logic        flag_q, flag_d;

  // Count the current hold run; any non-hold cycle restarts it.
  always_comb begin
    cnt_d  = '0;
    if (hold_i) begin
      cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end
    flag_d = flag_q | (hold_i && ({1'b0, cnt_d} >= Limit));
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign timeout_o = flag_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller for the dual-issue next-PC stage. Arbitrates execute
// and decode redirects against slot stalls, drives registered next-PC controls
// and owns the flush drain window.
// Optional statistics counters are enabled with `define FETCH_REDIR_STATS_EN.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES  = FLUSH_CYCLES_DEFAULT,
  parameter int unsigned STALL_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_redir_valid,
  input  logic        ex_redir_jalr,
  input  logic [11:0] ex_imm,
  input  logic [31:0] ex_target,
  input  logic        dec_jal_valid,
  input  logic [19:0] dec_imm_jal,
  input  logic        stall_a,
  input  logic        stall_b,
  output logic [1:0]  pc_src,
  output logic [11:0] imm_o,
  output logic [19:0] imm_jal_o,
  output logic [31:0] imm_jalr_o,
  output logic        hold_a,
  output logic        replay_b,
  output logic        flush_fd,
  output logic        stall_timeout,
  output logic [15:0] redir_cnt,
  output logic [15:0] stall_cnt
);

  localparam logic [DrainCntW-1:0] FlushInit = DrainCntW'(FLUSH_CYCLES);

  fetch_state_e         state_q, state_d;
  logic [DrainCntW-1:0] drain_q, drain_d;
  logic [1:0]           pc_src_q, pc_src_d;
  logic [11:0]          imm_q, imm_d;
  logic [19:0]          imm_jal_q, imm_jal_d;
  logic [31:0]          imm_jalr_q, imm_jalr_d;
  logic                 hold_q, hold_d;
  logic                 replay_q, replay_d;
  logic                 flush_q, flush_d;
  logic                 redir_acc;

  // Next-state and next-output decode. An execute redirect wins in every state
  // since it belongs to the oldest instruction in flight.
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    pc_src_d   = PCSRC_SEQ;
    imm_d      = imm_q;
    imm_jal_d  = imm_jal_q;
    imm_jalr_d = imm_jalr_q;
    hold_d     = 1'b0;
    replay_d   = 1'b0;
    flush_d    = 1'b0;
    redir_acc  = 1'b0;

    if (ex_redir_valid) begin
      redir_acc = 1'b1;
      state_d   = StDrain;
      drain_d   = FlushInit;
      flush_d   = 1'b1;
      if (ex_redir_jalr) begin
        pc_src_d   = PCSRC_JALR;
        imm_jalr_d = ex_target;
      end else begin
        pc_src_d = PCSRC_BR;
        imm_d    = ex_imm;
      end
    end else begin
      case (state_q)
        StRun: begin
          if (dec_jal_valid) begin
            redir_acc = 1'b1;
            pc_src_d  = PCSRC_JAL;
            imm_jal_d = dec_imm_jal;
            flush_d   = 1'b1;
            drain_d   = FlushInit;
            state_d   = StDrain;
          end else if (stall_a) begin
            hold_d  = 1'b1;
            state_d = StStall;
          end else if (stall_b) begin
            replay_d = 1'b1;
          end
        end
        StStall: begin
          // jal is held off until slot A is released.
          if (stall_a) begin
            hold_d = 1'b1;
          end else begin
            replay_d = stall_b;
            state_d  = StRun;
          end
        end
        StDrain: begin
          // Slot stalls and jal here come from squashed instructions.
          if (drain_q <= DrainCntW'(1)) begin
            drain_d = '0;
            state_d = StRun;
          end else begin
            drain_d = drain_q - DrainCntW'(1);
            flush_d = 1'b1;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      drain_q    <= '0;
      pc_src_q   <= PCSRC_SEQ;
      imm_q      <= '0;
      imm_jal_q  <= '0;
      imm_jalr_q <= '0;
      hold_q     <= 1'b0;
      replay_q   <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      pc_src_q   <= pc_src_d;
      imm_q      <= imm_d;
      imm_jal_q  <= imm_jal_d;
      imm_jalr_q <= imm_jalr_d;
      hold_q     <= hold_d;
      replay_q   <= replay_d;
      flush_q    <= flush_d;
    end
  end

  fetch_stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .hold_i   (hold_q),
    .timeout_o(stall_timeout)
  );

`ifdef FETCH_REDIR_STATS_EN
  logic [15:0] redir_cnt_q, stall_cnt_q;

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (redir_acc && (redir_cnt_q != 16'hFFFF)) redir_cnt_q <= redir_cnt_q + 16'd1;
      if (hold_q && (stall_cnt_q != 16'hFFFF))    stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign redir_cnt = redir_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  logic unused_redir_acc;
  assign unused_redir_acc = redir_acc;
  assign redir_cnt        = '0;
  assign stall_cnt        = '0;
`endif

  assign pc_src     = pc_src_q;
  assign imm_o      = imm_q;
  assign imm_jal_o  = imm_jal_q;
  assign imm_jalr_o = imm_jalr_q;
  assign hold_a     = hold_q;
  assign replay_b   = replay_q;
  assign flush_fd   = flush_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed self-checking bench for fetch_redirect_ctrl (default parameters:
// FLUSH_CYCLES=2, STALL_TIMEOUT=64).
module tb_fetch_redirect_ctrl;

`ifdef FETCH_REDIR_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_redir_valid, ex_redir_jalr, dec_jal_valid, stall_a, stall_b;
  logic [11:0] ex_imm;
  logic [31:0] ex_target;
  logic [19:0] dec_imm_jal;
  logic [1:0]  pc_src;
  logic [11:0] imm_o;
  logic [19:0] imm_jal_o;
  logic [31:0] imm_jalr_o;
  logic        hold_a, replay_b, flush_fd, stall_timeout;
  logic [15:0] redir_cnt, stall_cnt;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .ex_redir_valid(ex_redir_valid),
    .ex_redir_jalr (ex_redir_jalr),
    .ex_imm        (ex_imm),
    .ex_target     (ex_target),
    .dec_jal_valid (dec_jal_valid),
    .dec_imm_jal   (dec_imm_jal),
    .stall_a       (stall_a),
    .stall_b       (stall_b),
    .pc_src        (pc_src),
    .imm_o         (imm_o),
    .imm_jal_o     (imm_jal_o),
    .imm_jalr_o    (imm_jalr_o),
    .hold_a        (hold_a),
    .replay_b      (replay_b),
    .flush_fd      (flush_fd),
    .stall_timeout (stall_timeout),
    .redir_cnt     (redir_cnt),
    .stall_cnt     (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    rst = 1'b1;
    ex_redir_valid = 1'b0; ex_redir_jalr = 1'b0; ex_imm = '0; ex_target = '0;
    dec_jal_valid = 1'b0; dec_imm_jal = '0; stall_a = 1'b0; stall_b = 1'b0;
    step(2);
    rst = 1'b0;

    // Reset values and idle cycles.
    check("rst_pc_src", 32'(pc_src), 32'd0);
    check("rst_imm", 32'(imm_o), 32'd0);
    check("rst_imm_jalr", imm_jalr_o, 32'd0);
    check("rst_timeout", 32'(stall_timeout), 32'd0);
    check("rst_redir_cnt", 32'(redir_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("idle_pc_src", 32'(pc_src), 32'd0);
      check("idle_hold", 32'(hold_a), 32'd0);
      check("idle_flush", 32'(flush_fd), 32'd0);
    end

    // Taken branch: one-cycle pc_src pulse, flush for 2 cycles.
    ex_redir_valid = 1'b1; ex_redir_jalr = 1'b0; ex_imm = 12'h010;
    step(1);
    ex_redir_valid = 1'b0;
    check("br_pc_src", 32'(pc_src), 32'd1);
    check("br_imm", 32'(imm_o), 32'h010);
    check("br_flush0", 32'(flush_fd), 32'd1);
    check("br_redir_cnt", 32'(redir_cnt), StatsOn ? 32'd1 : 32'd0);
    step(1);
    check("br_pc_src_seq", 32'(pc_src), 32'd0);
    check("br_flush1", 32'(flush_fd), 32'd1);
    check("br_imm_hold", 32'(imm_o), 32'h010);
    step(1);
    check("br_flush_end", 32'(flush_fd), 32'd0);

    // jalr and jal together: execute wins, jal dropped.
    ex_redir_valid = 1'b1; ex_redir_jalr = 1'b1; ex_target = 32'h0001_0040;
    dec_jal_valid = 1'b1; dec_imm_jal = 20'h12345;
    step(1);
    ex_redir_valid = 1'b0; ex_redir_jalr = 1'b0; dec_jal_valid = 1'b0;
    check("jalr_pc_src", 32'(pc_src), 32'd3);
    check("jalr_target", imm_jalr_o, 32'h0001_0040);
    check("jalr_jal_not_loaded", 32'(imm_jal_o), 32'd0);
    step(1);
    check("jalr_no_jal_pulse0", 32'(pc_src), 32'd0);
    step(1);
    check("jalr_no_jal_pulse1", 32'(pc_src), 32'd0);
    check("jalr_flush_end", 32'(flush_fd), 32'd0);

    // Plain jal.
    dec_jal_valid = 1'b1; dec_imm_jal = 20'hABCDE;
    step(1);
    dec_jal_valid = 1'b0;
    check("jal_pc_src", 32'(pc_src), 32'd2);
    check("jal_imm", 32'(imm_jal_o), 32'hABCDE);
    check("jal_flush", 32'(flush_fd), 32'd1);
    step(2);
    check("jal_flush_end", 32'(flush_fd), 32'd0);

    // stall_a for 3 cycles with stall_b held, then release stall_a.
    stall_a = 1'b1; stall_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("stall_hold", 32'(hold_a), 32'd1);
      check("stall_no_replay", 32'(replay_b), 32'd0);
    end
    stall_a = 1'b0;
    step(1);
    stall_b = 1'b0;
    check("stall_release_hold", 32'(hold_a), 32'd0);
    check("stall_release_replay", 32'(replay_b), 32'd1);
    step(1);
    check("stall_replay_done", 32'(replay_b), 32'd0);
    check("stall_run_hold", 32'(hold_a), 32'd0);

    // stall_b alone in RUN replays slot B.
    stall_b = 1'b1;
    step(1);
    stall_b = 1'b0;
    check("b_only_replay", 32'(replay_b), 32'd1);
    check("b_only_hold", 32'(hold_a), 32'd0);

    // Drain: stall_a and jal ignored; a second ex redirect restarts the window.
    ex_redir_valid = 1'b1; ex_imm = 12'h7F0;
    step(1);
    ex_redir_valid = 1'b0;
    check("dr_pc_src", 32'(pc_src), 32'd1);
    stall_a = 1'b1; dec_jal_valid = 1'b1; dec_imm_jal = 20'h55555;
    step(1);
    check("dr_hold_ignored", 32'(hold_a), 32'd0);
    check("dr_pc_src_seq", 32'(pc_src), 32'd0);
    check("dr_flush", 32'(flush_fd), 32'd1);
    ex_redir_valid = 1'b1; ex_redir_jalr = 1'b1; ex_target = 32'h0000_2000;
    step(1);
    ex_redir_valid = 1'b0; ex_redir_jalr = 1'b0;
    check("dr2_pc_src", 32'(pc_src), 32'd3);
    check("dr2_target", imm_jalr_o, 32'h0000_2000);
    check("dr2_flush", 32'(flush_fd), 32'd1);
    step(1);
    check("dr2_restart_flush", 32'(flush_fd), 32'd1);
    check("dr2_hold_ignored", 32'(hold_a), 32'd0);
    check("dr2_jal_ignored", 32'(imm_jal_o), 32'hABCDE);
    step(1);
    stall_a = 1'b0; dec_jal_valid = 1'b0;
    check("dr2_flush_end", 32'(flush_fd), 32'd0);
    check("dr2_pc_src_end", 32'(pc_src), 32'd0);
    check("dr2_redir_cnt", 32'(redir_cnt), StatsOn ? 32'd5 : 32'd0);

    // Asynchronous reset in the middle of a drain.
    ex_redir_valid = 1'b1; ex_imm = 12'h123;
    step(1);
    ex_redir_valid = 1'b0;
    check("ar_flush_before", 32'(flush_fd), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_flush", 32'(flush_fd), 32'd0);
    check("ar_pc_src", 32'(pc_src), 32'd0);
    check("ar_imm", 32'(imm_o), 32'd0);
    check("ar_imm_jalr", imm_jalr_o, 32'd0);
    check("ar_redir_cnt", 32'(redir_cnt), 32'd0);
    step(1);
    rst = 1'b0;
    step(1);
    check("ar_idle_flush", 32'(flush_fd), 32'd0);

    // Watchdog: 64 consecutive hold cycles set the sticky flag.
    stall_a = 1'b1;
    step(1);
    check("wd_hold", 32'(hold_a), 32'd1);
    step(63);
    check("wd_before_limit", 32'(stall_timeout), 32'd0);
    step(1);
    check("wd_at_limit", 32'(stall_timeout), 32'd1);
    check("wd_stall_cnt", 32'(stall_cnt), StatsOn ? 32'd64 : 32'd0);
    stall_a = 1'b0;
    step(1);
    check("wd_release_hold", 32'(hold_a), 32'd0);
    step(3);
    check("wd_sticky", 32'(stall_timeout), 32'd1);
    rst = 1'b1;
    #1;
    check("wd_rst_clear", 32'(stall_timeout), 32'd0);
    check("wd_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    step(1);
    rst = 1'b0;
    step(2);
    check("wd_after_rst", 32'(stall_timeout), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Sequences the dual-issue next-PC/fetch stage: arbitrates redirect requests from execute (branch, jalr) and decode (jal) against slot-A/slot-B back-pressure, and drives the PC-source select, immediate/target operands and hold/replay controls of the next-PC logic.
- Owns flush timing: on redirect, squashes in-flight fetch/decode slots for a fixed drain window and suppresses stale stall/error indications.
- Sits between the decode/issue/execute feedback paths and the next-PC register block.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_fd stays asserted after an accepted redirect (1..7).
- STALL_TIMEOUT, 64, consecutive hold_a cycles before stall_timeout sets (power of two, ≥4).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ex_redir_valid  in  1  execute redirect request
- ex_redir_jalr  in  1  1 = jalr (absolute target), 0 = taken branch (relative imm)
- ex_imm  in  12  branch offset
- ex_target  in  32  jalr absolute target
- dec_jal_valid  in  1  decode jal request
- dec_imm_jal  in  20  jal immediate
- stall_a  in  1  slot-A stall (error | rs full | decode error, ORed upstream)
- stall_b  in  1  slot-B stall
- pc_src  out  2  00 seq, 01 branch, 10 jal, 11 jalr
- imm_o  out  12  branch immediate to next-PC logic
- imm_jal_o  out  20  jal immediate
- imm_jalr_o  out  32  jalr target
- hold_a  out  1  freeze both PCs
- replay_b  out  1  shift pcF2 into pcF1
- flush_fd  out  1  squash fetch/decode slots
- stall_timeout  out  1  sticky watchdog flag
- redir_cnt  out  16  accepted-redirect count (feature-gated)
- stall_cnt  out  16  hold_a cycle count (feature-gated)

Behaviour:
- All outputs registered; a request sampled at edge N drives outputs in cycle N+1. Reset: state=RUN, pc_src=00, immediates 0, hold_a=replay_b=flush_fd=0, stall_timeout=0, counters 0.
- States: RUN, STALL, DRAIN.
- Priority per cycle: ex_redir_valid > dec_jal_valid > stall_a > stall_b.
- RUN: ex redirect → pc_src=01/11, load imm_o or imm_jalr_o, flush_fd=1, drain counter=FLUSH_CYCLES, go to DRAIN. jal → pc_src=10, load imm_jal_o, flush_fd=1, go to DRAIN. stall_a → hold_a=1, go to STALL. stall_b only → replay_b=1 for one cycle, stay in RUN. Otherwise pc_src=00.
- pc_src≠00 for exactly one cycle per accepted redirect, then returns to 00. Immediate outputs hold their last loaded value.
- STALL: hold_a=1 while stall_a. An ex redirect preempts: hold_a=0 and the redirect is taken as in RUN. jal is ignored while stall_a. When stall_a drops: with stall_b → replay_b=1, go to RUN; without stall_b → RUN.
- DRAIN: flush_fd=1 and pc_src=00; stall_a/stall_b/jal ignored (squashed instructions). The counter decrements each cycle, and the FSM goes to RUN when it reaches 1. A new ex redirect during DRAIN is accepted (older instruction): reload target, restart the counter.
- Watchdog: 16-bit-capped counter increments on each hold_a cycle and clears on any non-hold cycle. At STALL_TIMEOUT, stall_timeout=1 and stays set until rst.
- Async rst mid-redirect or mid-drain returns all outputs to reset values immediately.

Optional Feature:
- FETCH_REDIR_STATS_EN defined: redir_cnt increments per accepted redirect (ex or jal), and stall_cnt per hold_a cycle. Both saturate at 16'hFFFF.
- Not defined: both ports tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package: pc_src encodings (PCSRC_SEQ/BR/JAL/JALR), FSM state encodings, default FLUSH_CYCLES.
- One natural sub-module: fetch_stall_watchdog (timeout counter + sticky flag).

Test Plan:
- Reset then idle → pc_src=00, hold_a=0, flush_fd=0 every cycle.
- ex_redir_valid=1, jalr=0, ex_imm=12'h010 at cycle 5 → cycle 6: pc_src=01, imm_o=12'h010, flush_fd=1. flush_fd stays 1 for FLUSH_CYCLES cycles. Cycle 7: pc_src=00.
- ex jalr (target 32'h0001_0040) and dec_jal_valid in the same cycle → pc_src=11 and imm_jalr_o=32'h0001_0040; jal dropped, no pc_src=10 follows.
- stall_a for 3 cycles with stall_b held, then release → hold_a=1 for 3 cycles, then replay_b=1 for one cycle, then RUN.
- During DRAIN: stall_a=1 and dec_jal_valid=1 → both ignored. A second ex redirect mid-drain → new pc_src pulse and counter restart.
- stall_a held STALL_TIMEOUT cycles → stall_timeout=1 and stays 1 after stall_a drops. rst pulse → 0. With FETCH_REDIR_STATS_EN, stall_cnt=64.
